ftch_stage: RTL
===============

Name: ftch_stage

Overview:
- Instruction fetch stage: PC generator, instruction-memory requester and in-order fetch queue.
- Issues word-aligned fetch requests to imem and pairs each returned instruction with its PC.
- Drives decode over the ftch_dec valid/ready channel.
- Execute redirects (taken branch/jump) flush queued and in-flight fetches and restart at the new PC.

Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.
- FQ_DEPTH, 4, fetch queue entries; also the cap on (in-flight requests + queued entries). Must be ≥2.

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-high reset
- imem_req_vld  output  1  fetch request valid
- imem_req_rdy  input  1  imem accepts request
- imem_req_addr  output  32  fetch byte address; bits [1:0] always 0
- imem_rsp_vld  input  1  instruction returned; in order, one per accepted request, earliest cycle after acceptance, always accepted
- imem_rsp_data  input  32  instruction word
- redir_vld  input  1  redirect from execute
- redir_pc  input  32  redirect target; bits [1:0] ignored and forced to 0
- ftch_dec_vld  output  1  packet to decode valid
- ftch_dec_rdy  input  1  decode accepts packet
- ftch_dec_pkt  output  64  ftch_dec_pkt_t: {pc[31:0], instr[31:0]}

Behaviour:
- Reset (async assert, takes effect immediately):
  - pc = RESET_PC, rsp_pc = RESET_PC; queue empty; out_cnt = 0, drop_cnt = 0.
  - imem_req_vld = 0, ftch_dec_vld = 0, ftch_dec_pkt = 0.
- Counters: out_cnt and drop_cnt are clog2(FQ_DEPTH+1) bits wide; occupancy is the queue entry count.
- Request generation:
  - imem_req_vld = (out_cnt + occupancy < FQ_DEPTH) && !redir_vld; imem_req_addr = pc.
  - Address is not required to stay stable while unaccepted; imem samples only on handshake.
  - On vld && rdy: pc <= pc + 4 (wraps modulo 2^32), out_cnt increments.
- Response capture:
  - Each imem_rsp_vld decrements out_cnt.
  - If drop_cnt == 0: push {rsp_pc, imem_rsp_data}, then rsp_pc <= rsp_pc + 4.
  - Otherwise discard and decrement drop_cnt.
- Credit guarantee: the credit check means a push never meets a full queue. Overflow is an assertion failure.
- Output:
  - ftch_dec_vld = queue non-empty; ftch_dec_pkt = head entry, driven from registers.
  - Pop on ftch_dec_vld && ftch_dec_rdy.
  - Latency: a response in cycle N is visible to decode in cycle N+1.
  - Head stays stable while vld && !rdy.
- Simultaneous push and pop: allowed in the same cycle, including when the queue is full (pop frees the slot first) or empty (entry appears next cycle).
- Redirect (redir_vld = 1 in cycle R):
  - No request issued in R.
  - Next cycle: queue empty, ftch_dec_vld = 0, pc = rsp_pc = {redir_pc[31:2], 2'b00}.
  - drop_cnt <= out_cnt after cycle-R accounting; a response arriving in R is discarded.
  - A decode handshake in R completes normally (decode squashes it).
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Requests resume from cycle R+1 subject to credit. Stale responses never reach decode.
- Reset mid-operation: all in-flight requests are abandoned. The imem is reset by the same signal.

Test Plan:
- Release reset, imem rdy=1, 1-cycle response latency, decode rdy=1:
  - first request addr 0xBFC00000, then +4 each cycle.
  - decode receives pc 0xBFC00000/instr = model data two cycles after request, one packet per cycle.
- Hold ftch_dec_rdy=0:
  - exactly 4 requests issue, queue fills, imem_req_vld drops.
  - pkt pc 0xBFC00000 is held stable.
  - rdy=1 drains in order, and requests restart one cycle after the first pop.
- imem latency 3 cycles, then redir_vld with redir_pc=0x0040_0013 while 2 requests are in flight:
  - both stale responses are dropped.
  - next request addr 0x0040_0010; first decode pc 0x0040_0010.
- Redirect in the same cycle as an imem response and a decode handshake:
  - response discarded, handshake completes, ftch_dec_vld=0 the next cycle.
  - no stale pc is delivered afterwards.
- pc wrap: redirect to 0xFFFF_FFFC → requests 0xFFFF_FFFC then 0x0000_0000; packet pcs match.
- Assert reset asynchronously mid-stream with queue full → outputs zero immediately; fetch restarts at 0xBFC00000 after deassert.

Source files
------------

// File: rtl/ftch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ftch_stage                                                    |
// | Function : Instruction fetch stage with PC generation, imem request      |
// |            credit control, in-order fetch queue and redirect flush.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ftch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_vld,
  input  logic        imem_req_rdy,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_vld,
  input  logic [31:0] imem_rsp_data,
  input  logic        redir_vld,
  input  logic [31:0] redir_pc,
  output logic        ftch_dec_vld,
  input  logic        ftch_dec_rdy,
  output logic [63:0] ftch_dec_pkt
);

  localparam int               c_CNT_W   = $clog2(FQ_DEPTH + 1);
  localparam int               c_PTR_W   = $clog2(FQ_DEPTH);
  localparam logic [c_CNT_W:0] c_DEPTH_X = (c_CNT_W + 1)'(FQ_DEPTH);

  logic [31:0]        r_pc;
  logic [31:0]        r_rsp_pc;
  logic [63:0]        r_q [FQ_DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;
  logic [c_CNT_W-1:0] r_out_cnt;
  logic [c_CNT_W-1:0] r_drop_cnt;

  logic [31:0]        w_redir_pc;
  logic [c_CNT_W:0]   w_credit_used;
  logic               w_req_fire;
  logic               w_pop;
  logic               w_push;
  logic               w_full;
  logic [c_CNT_W-1:0] w_out_nxt;
  logic               w_unused_redir_lsb;

  function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(FQ_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  assign w_redir_pc         = {redir_pc[31:2], 2'b00};
  assign w_unused_redir_lsb = ^redir_pc[1:0];

  // Credits cover both in-flight requests and queued entries, so a push never finds the queue full.
  assign w_credit_used = {1'b0, r_out_cnt} + {1'b0, r_count};
  assign imem_req_vld  = (w_credit_used < c_DEPTH_X) && !redir_vld && !reset;
  assign imem_req_addr = r_pc;
  assign w_req_fire    = imem_req_vld && imem_req_rdy;

  assign ftch_dec_vld  = (r_count != '0);
  assign ftch_dec_pkt  = r_q[r_head];
  assign w_pop         = ftch_dec_vld && ftch_dec_rdy;

  assign w_push        = imem_rsp_vld && (r_drop_cnt == '0) && !redir_vld;
  assign w_full        = (r_count == c_CNT_W'(FQ_DEPTH));
  assign w_out_nxt     = r_out_cnt + c_CNT_W'(w_req_fire) - c_CNT_W'(imem_rsp_vld);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      r_out_cnt <= w_out_nxt;
      if (redir_vld) begin
        // Everything still outstanding after this cycle's accounting belongs to the old path.
        r_pc       <= w_redir_pc;
        r_rsp_pc   <= w_redir_pc;
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_drop_cnt <= w_out_nxt;
      end else begin
        if (w_req_fire) begin
          r_pc <= r_pc + 32'd4;
        end
        if (imem_rsp_vld) begin
          if (r_drop_cnt == '0) begin
            r_rsp_pc <= r_rsp_pc + 32'd4;
          end else begin
            r_drop_cnt <= r_drop_cnt - c_CNT_W'(1);
          end
        end
        if (w_push) begin
          r_q[r_tail] <= {r_rsp_pc, imem_rsp_data};
          r_tail      <= f_ptr_inc(r_tail);
        end
        if (w_pop) begin
          r_head <= f_ptr_inc(r_head);
        end
        r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(w_push && !w_pop && w_full));

endmodule
`default_nettype wire
